// File: rtl/axi_slave_wr_ctrl_pkg.sv
// Shared types and constants for the AXI4 slave write-channel controller.
package axi_wr_ctrl_pkg;

  // Burst sequencing: wait for a command, stream its beats, return B.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } wr_state_e;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;

  // Field positions inside the packed write-data FIFO word.
  localparam int LAST_BIT = 36;
  localparam int STRB_LSB = 32;
  localparam int DATA_LSB = 0;

  // Eight-bit increment that sticks at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/axi_slave_wr_ctrl_aw_cmd_queue.sv
// Small synchronous FIFO of accepted AW commands {id, len}.
// Push is ignored when full and pop is ignored when empty, so a slot freed
// by a pop becomes visible to the writer only on the following cycle.
module axi_aw_cmd_queue #(
  parameter int ID_WIDTH    = 4,
  parameter int DEPTH_WIDTH = 2
) (
  input  logic                clk,
  input  logic                tb_rst,
  input  logic                push,
  input  logic [ID_WIDTH-1:0] push_id,
  input  logic [7:0]          push_len,
  input  logic                pop,
  output logic                full,
  output logic                empty,
  output logic [ID_WIDTH-1:0] head_id,
  output logic [7:0]          head_len
);

  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] FULL_CNT = (DEPTH_WIDTH + 1)'(DEPTH);

  logic [ID_WIDTH-1:0]    mem_id  [DEPTH];
  logic [7:0]             mem_len [DEPTH];
  logic [DEPTH_WIDTH-1:0] wr_ptr;
  logic [DEPTH_WIDTH-1:0] rd_ptr;
  logic [DEPTH_WIDTH:0]   count;
  logic                   do_push;
  logic                   do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign head_id  = mem_id[rd_ptr];
  assign head_len = mem_len[rd_ptr];

  // Entry storage; only written on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_id[wr_ptr]  <= push_id;
      mem_len[wr_ptr] <= push_len;
    end
  end

  // Pointers and occupancy; reset empties the queue and drops its contents.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_slave_wr_ctrl.sv
// AXI4 slave write-channel controller: queues AW commands, admits W beats
// only against the command at the queue head, packs each beat into the
// write-data FIFO and returns one B response per burst.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. A valid, once raised, is held with its payload stable until
// that edge; ready may rise and fall freely and never waits on valid.
module axi_slave_wr_ctrl
  import axi_wr_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int STRB_WIDTH      = 4,
  parameter int FIFO_WIDTH      = 37,
  parameter int ID_WIDTH        = 4,
  parameter int CMD_DEPTH_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  tb_rst,
  input  logic [ID_WIDTH-1:0]   s_awid,
  input  logic [7:0]            s_awlen,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  input  logic [STRB_WIDTH-1:0] s_wstrb,
  input  logic                  s_wlast,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [ID_WIDTH-1:0]   s_bid,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  output logic [FIFO_WIDTH-1:0] fifo_wr_data,
  output logic                  fifo_wr_en,
  input  logic                  fifo_full,
  input  logic                  fifo_almost_full,
  output logic [7:0]            err_cnt,
  output wr_state_e             dbg_state
);

  wr_state_e           state;
  logic [7:0]          beat_cnt;
  logic [7:0]          cur_len;
  logic [ID_WIDTH-1:0] cur_id;
  logic                err_flag;

  logic                q_full;
  logic                q_empty;
  logic [ID_WIDTH-1:0] head_id;
  logic [7:0]          head_len;

  logic                aw_hs;
  logic                w_hs;
  logic                b_hs;
  logic                exp_last;
  logic                last_err;

  // Command acceptance depends only on the current occupancy; reset holds it low.
  assign s_awready = ~q_full & ~tb_rst;
  assign aw_hs     = s_awvalid & s_awready;

  // Beats flow only while a burst is open and the FIFO has headroom for the
  // one-cycle registered write still in flight.
  assign s_wready  = (state == ST_DATA) & ~fifo_almost_full & ~fifo_full;
  assign w_hs      = s_wvalid & s_wready;
  assign b_hs      = s_bvalid & s_bready;

  // The burst is framed by the beat count; s_wlast is only cross-checked.
  assign exp_last  = (beat_cnt == cur_len);
  assign last_err  = s_wlast ^ exp_last;

  assign dbg_state = state;

  axi_aw_cmd_queue #(
    .ID_WIDTH   (ID_WIDTH),
    .DEPTH_WIDTH(CMD_DEPTH_WIDTH)
  ) u_cmd_queue (
    .clk     (clk),
    .tb_rst  (tb_rst),
    .push    (aw_hs),
    .push_id (s_awid),
    .push_len(s_awlen),
    .pop     (b_hs),
    .full    (q_full),
    .empty   (q_empty),
    .head_id (head_id),
    .head_len(head_len)
  );

  // Burst FSM with registered B channel and error accounting.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      cur_len  <= '0;
      cur_id   <= '0;
      err_flag <= 1'b0;
      s_bvalid <= 1'b0;
      s_bid    <= '0;
      s_bresp  <= BRESP_OKAY;
      err_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!q_empty) begin
            state    <= ST_DATA;
            beat_cnt <= '0;
            cur_len  <= head_len;
            cur_id   <= head_id;
            err_flag <= 1'b0;
          end
        end
        ST_DATA: begin
          if (w_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (last_err) err_flag <= 1'b1;
            if (exp_last) begin
              state    <= ST_RESP;
              s_bvalid <= 1'b1;
              s_bid    <= cur_id;
              s_bresp  <= (err_flag | last_err) ? BRESP_SLVERR : BRESP_OKAY;
            end
          end
        end
        ST_RESP: begin
          if (s_bready) begin
            state    <= ST_IDLE;
            s_bvalid <= 1'b0;
            if (err_flag) err_cnt <= sat_inc8(err_cnt);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Registered FIFO write, one cycle behind the W handshake.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
    end else begin
      fifo_wr_en <= w_hs;
      if (w_hs) fifo_wr_data <= {exp_last, s_wstrb, s_wdata};
    end
  end

endmodule

// File: tb/tb_axi_slave_wr_ctrl.sv
// Bench for axi_slave_wr_ctrl: a table of bursts plus hand-written
// sequences for backpressure, queue-full, idle W and mid-burst reset.
module tb_axi_slave_wr_ctrl;
  import axi_wr_ctrl_pkg::*;

  localparam int DW = 32;
  localparam int SW = 4;
  localparam int FW = 37;
  localparam int IW = 4;

  logic          clk;
  logic          tb_rst;
  logic [IW-1:0] s_awid;
  logic [7:0]    s_awlen;
  logic          s_awvalid;
  logic          s_awready;
  logic [DW-1:0] s_wdata;
  logic [SW-1:0] s_wstrb;
  logic          s_wlast;
  logic          s_wvalid;
  logic          s_wready;
  logic [IW-1:0] s_bid;
  logic [1:0]    s_bresp;
  logic          s_bvalid;
  logic          s_bready;
  logic [FW-1:0] fifo_wr_data;
  logic          fifo_wr_en;
  logic          fifo_full;
  logic          fifo_almost_full;
  logic [7:0]    err_cnt;
  wr_state_e     dbg_state;

  axi_slave_wr_ctrl dut (
    .clk             (clk),
    .tb_rst          (tb_rst),
    .s_awid          (s_awid),
    .s_awlen         (s_awlen),
    .s_awvalid       (s_awvalid),
    .s_awready       (s_awready),
    .s_wdata         (s_wdata),
    .s_wstrb         (s_wstrb),
    .s_wlast         (s_wlast),
    .s_wvalid        (s_wvalid),
    .s_wready        (s_wready),
    .s_bid           (s_bid),
    .s_bresp         (s_bresp),
    .s_bvalid        (s_bvalid),
    .s_bready        (s_bready),
    .fifo_wr_data    (fifo_wr_data),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_full       (fifo_full),
    .fifo_almost_full(fifo_almost_full),
    .err_cnt         (err_cnt),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int b_seen = 0;
  int b_target = 0;

  logic [FW-1:0]   exp_q[$];
  logic [IW+1:0]   exp_b_q[$];
  logic [FW-1:0]   e_w;
  logic [IW+1:0]   e_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] pack_word(input logic last, input logic [SW-1:0] strb,
                                              input logic [DW-1:0] data);
    logic [FW-1:0] w;
    w = '0;
    w[LAST_BIT] = last;
    w[STRB_LSB +: SW] = strb;
    w[DATA_LSB +: DW] = data;
    return w;
  endfunction

  // FIFO-side and B-side monitors pop the expected queues.
  always @(negedge clk) begin
    if (!tb_rst && fifo_wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fifo_unexpected: got 0x%0h expected no write", fifo_wr_data);
      end else begin
        e_w = exp_q.pop_front();
        chk("fifo_word", 64'(fifo_wr_data), 64'(e_w));
      end
    end
    if (!tb_rst && s_bvalid && s_bready) begin
      if (exp_b_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected: got id=0x%0h resp=%0b expected no response", s_bid, s_bresp);
      end else begin
        e_b = exp_b_q.pop_front();
        chk("b_id_resp", 64'({s_bid, s_bresp}), 64'(e_b));
      end
      b_seen++;
    end
  end

  // ---------------- drivers ----------------
  task automatic send_aw(input logic [IW-1:0] id, input logic [7:0] len, input logic [1:0] resp);
    bit ok;
    ok = 0;
    s_awid = id;
    s_awlen = len;
    s_awvalid = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (s_awready) begin
        ok = 1;
        break;
      end
    end
    if (ok) begin
      exp_b_q.push_back({id, resp});
      @(posedge clk);
      #1;
    end else begin
      checks++;
      errors++;
      $display("FAIL aw_timeout: got awready=0 expected 1 within 1000 cycles");
    end
    s_awvalid = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] data, input logic [SW-1:0] strb,
                           input logic last, input logic exp_last);
    bit ok;
    ok = 0;
    s_wdata = data;
    s_wstrb = strb;
    s_wlast = last;
    s_wvalid = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (s_wready) begin
        ok = 1;
        break;
      end
    end
    if (ok) begin
      exp_q.push_back(pack_word(exp_last, strb, data));
      @(posedge clk);
      #1;
    end else begin
      checks++;
      errors++;
      $display("FAIL w_timeout: got wready=0 expected 1 within 1000 cycles");
    end
    s_wvalid = 1'b0;
  endtask

  task automatic run_burst(input logic [IW-1:0] id, input logic [7:0] len, input logic [DW-1:0] base,
                           input logic [SW-1:0] strb, input int bad, input logic [1:0] resp);
    logic el;
    send_aw(id, len, resp);
    for (int i = 0; i <= int'(len); i++) begin
      el = (i == int'(len));
      send_beat(base + DW'(i), strb, el ^ (i == bad), el);
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_b(input int target);
    bit ok;
    ok = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (b_seen >= target) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL b_timeout: got %0d responses expected %0d", b_seen, target);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [IW-1:0] id;
    logic [7:0]    len;
    logic [DW-1:0] base;
    logic [SW-1:0] strb;
    int            bad;
    logic [1:0]    resp;
    logic [7:0]    exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{4'h3, 8'd0,   32'h1234_5678, 4'hF, -1, BRESP_OKAY,   8'd0};
    vecs[1] = '{4'h5, 8'd3,   32'h0000_0000, 4'hF, -1, BRESP_OKAY,   8'd0};
    vecs[2] = '{4'h1, 8'd1,   32'h0000_A000, 4'h3,  0, BRESP_SLVERR, 8'd1};
    vecs[3] = '{4'hF, 8'd0,   32'hBEEF_0000, 4'h0,  0, BRESP_SLVERR, 8'd2};
    vecs[4] = '{4'h7, 8'd15,  32'h0000_0100, 4'h5, -1, BRESP_OKAY,   8'd2};
    vecs[5] = '{4'h9, 8'd255, 32'h55AA_0000, 4'hF, -1, BRESP_OKAY,   8'd2};
    vecs[6] = '{4'h2, 8'd2,   32'hC0DE_0000, 4'hC,  2, BRESP_SLVERR, 8'd3};
  end

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    tb_rst = 1'b1;
    s_awid = '0;
    s_awlen = '0;
    s_awvalid = 1'b0;
    s_wdata = '0;
    s_wstrb = '0;
    s_wlast = 1'b0;
    s_wvalid = 1'b0;
    s_bready = 1'b1;
    fifo_full = 1'b0;
    fifo_almost_full = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 64'(s_awready), 64'd0);
    chk("rst_wready", 64'(s_wready), 64'd0);
    chk("rst_bvalid", 64'(s_bvalid), 64'd0);
    chk("rst_bid_bresp", 64'({s_bid, s_bresp}), 64'd0);
    chk("rst_fifo", 64'({fifo_wr_en, fifo_wr_data}), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    tb_rst = 1'b0;
    @(negedge clk);
    chk("awready_after_rst", 64'(s_awready), 64'd1);
    @(posedge clk);
    #1;

    // Table-driven bursts.
    for (int i = 0; i < 7; i++) begin
      run_burst(vecs[i].id, vecs[i].len, vecs[i].base, vecs[i].strb, vecs[i].bad, vecs[i].resp);
      b_target++;
      wait_b(b_target);
      chk("err_cnt", 64'(err_cnt), 64'(vecs[i].exp_err));
      chk("bvalid_cleared", 64'(s_bvalid), 64'd0);
    end

    // W presented with no command: must be held off.
    s_wdata = 32'hDEAD_BEEF;
    s_wstrb = 4'hF;
    s_wlast = 1'b1;
    s_wvalid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_wready", 64'(s_wready), 64'd0);
    end
    chk("idle_state", 64'(dbg_state), 64'(ST_IDLE));
    @(posedge clk);
    #1;
    s_wvalid = 1'b0;

    // Backpressure mid-burst: almost_full for 10 cycles, then full alone.
    send_aw(4'h2, 8'd7, BRESP_OKAY);
    for (int i = 0; i < 3; i++) send_beat(32'h0B00_0000 + 32'(i), 4'hF, 1'b0, 1'b0);
    fifo_almost_full = 1'b1;
    s_wdata = 32'h0B00_0003;
    s_wstrb = 4'hF;
    s_wlast = 1'b0;
    s_wvalid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_wready", 64'(s_wready), 64'd0);
      if (c > 0) chk("bp_wr_en", 64'(fifo_wr_en), 64'd0);
    end
    @(posedge clk);
    #1;
    fifo_almost_full = 1'b0;
    fifo_full = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("full_wready", 64'(s_wready), 64'd0);
    end
    @(posedge clk);
    #1;
    fifo_full = 1'b0;
    for (int i = 3; i < 8; i++) send_beat(32'h0B00_0000 + 32'(i), 4'hF, i == 7, i == 7);
    b_target++;
    wait_b(b_target);

    // Queue full: four commands fill it, a fifth waits for the first B.
    s_bready = 1'b0;
    for (int k = 0; k < 4; k++) send_aw(IW'(10 + k), 8'd0, BRESP_OKAY);
    @(negedge clk);
    chk("aw_full", 64'(s_awready), 64'd0);
    @(posedge clk);
    #1;
    s_awid = 4'd14;
    s_awlen = 8'd0;
    s_awvalid = 1'b1;
    exp_b_q.push_back({4'd14, BRESP_OKAY});
    send_beat(32'h0000_000A, 4'hF, 1'b1, 1'b1);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (s_bvalid) break;
    end
    repeat (3) begin
      chk("b_hold", 64'({s_bvalid, s_bid, s_bresp}), 64'({1'b1, 4'd10, BRESP_OKAY}));
      chk("aw_still_full", 64'(s_awready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    s_bready = 1'b1;
    @(negedge clk);
    chk("aw_full_at_b", 64'(s_awready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("aw_reopen", 64'(s_awready), 64'd1);
    @(posedge clk);
    #1;
    s_awvalid = 1'b0;
    for (int k = 11; k < 15; k++) send_beat(32'h0000_0000 + 32'(k), 4'hF, 1'b1, 1'b1);
    b_target += 5;
    wait_b(b_target);

    // Reset on beat 2 of an 8-beat burst.
    send_aw(4'h6, 8'd7, BRESP_OKAY);
    send_beat(32'h0600_0000, 4'hF, 1'b0, 1'b0);
    send_beat(32'h0600_0001, 4'hF, 1'b0, 1'b0);
    s_wdata = 32'h0600_0002;
    s_wlast = 1'b0;
    s_wvalid = 1'b1;
    tb_rst = 1'b1;
    #1;
    chk("midrst_ready", 64'({s_awready, s_wready}), 64'd0);
    chk("midrst_b", 64'({s_bvalid, s_bid, s_bresp}), 64'd0);
    chk("midrst_fifo", 64'({fifo_wr_en, fifo_wr_data}), 64'd0);
    chk("midrst_err_cnt", 64'(err_cnt), 64'd0);
    exp_q.delete();
    exp_b_q.delete();
    s_wvalid = 1'b0;
    @(posedge clk);
    #1;
    tb_rst = 1'b0;
    run_burst(4'h4, 8'd0, 32'h4444_0000, 4'hF, -1, BRESP_OKAY);
    b_target++;
    wait_b(b_target);
    chk("post_rst_err_cnt", 64'(err_cnt), 64'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("fifo_exp_drained", 64'(exp_q.size()), 64'd0);
    chk("b_exp_drained", 64'(exp_b_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
